// File: rtl/adc_seq_ctrl_if.sv
// Output sample stream of adc_seq_ctrl (valid/ready handshake, slot-tagged 12-bit samples).
interface adc_seq_ctrl_if;
  // A transfer happens on every clock edge where sample_valid and sample_ready are both 1;
  // while sample_valid=1 and sample_ready=0 the source holds sample_data/sample_slot stable.
  logic        sample_valid;
  logic        sample_ready;
  logic [11:0] sample_data;
  logic [5:0]  sample_slot;

  modport master (output sample_valid, output sample_data, output sample_slot, input sample_ready);
  modport slave  (input sample_valid, input sample_data, input sample_slot, output sample_ready);
endinterface

// File: rtl/adc_seq_ctrl.sv
// CSR sequencer for the ADC core: arm IRQ, run, wait IRQ, read NSLOT samples, stream, clear.
// Optional watchdog on WAIT_IRQ is enabled by defining ADC_SEQ_CTRL_WDOG_EN.
module adc_seq_ctrl #(
  parameter int NSLOT   = 8,
  parameter int RD_LAT  = 2,
  parameter int TMO_CYC = 4096
) (
  input  logic                  clock_clk,
  input  logic                  reset_sink_reset,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  adc_seq_ctrl_if.master        smp,
  output logic                  sequencer_csr_address,
  output logic                  sequencer_csr_read,
  output logic                  sequencer_csr_write,
  output logic [31:0]           sequencer_csr_writedata,
  input  logic [31:0]           sequencer_csr_readdata,
  output logic [6:0]            sample_store_csr_address,
  output logic                  sample_store_csr_read,
  output logic                  sample_store_csr_write,
  output logic [31:0]           sample_store_csr_writedata,
  input  logic [31:0]           sample_store_csr_readdata,
  input  logic                  sample_store_irq_irq,
  output logic                  error,
  output logic [3:0]            dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ARM      = 4'd1,
    S_RUN      = 4'd2,
    S_WAIT_IRQ = 4'd3,
    S_RD       = 4'd4,
    S_RWAIT    = 4'd5,
    S_OUT      = 4'd6,
    S_CLR      = 4'd7,
    S_STOP     = 4'd8
  } state_t;

  state_t      state, state_d;
  logic [5:0]  slot_q;
  logic [7:0]  lat_q;
  logic [11:0] data_q;
  logic        cont_q, stop_q;
  logic        wdog_hit, abort_q;
  logic        last_slot, handshake;

  assign last_slot = (slot_q == 6'(NSLOT - 1));
  assign handshake = (state == S_OUT) && smp.sample_ready;

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      state  <= S_IDLE;
      slot_q <= '0;
      lat_q  <= '0;
      data_q <= '0;
      cont_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      state <= state_d;
      // A stop arriving together with an accepted start still lets that one sequence run.
      if (state == S_IDLE) begin
        if (start) begin
          cont_q <= cont;
          stop_q <= stop;
        end else begin
          stop_q <= 1'b0;
        end
      end else if (stop) begin
        stop_q <= 1'b1;
      end
      if ((state == S_WAIT_IRQ) && sample_store_irq_irq)
        slot_q <= '0;
      else if (handshake && !last_slot)
        slot_q <= slot_q + 6'd1;
      lat_q <= (state == S_RWAIT) ? lat_q + 8'd1 : 8'd0;
      if ((state == S_RWAIT) && (lat_q == 8'(RD_LAT - 1)))
        data_q <= sample_store_csr_readdata[11:0];
    end
  end

  always_comb begin
    state_d                    = state;
    sequencer_csr_address      = 1'b0;
    sequencer_csr_read         = 1'b0;
    sequencer_csr_write        = 1'b0;
    sequencer_csr_writedata    = 32'd0;
    sample_store_csr_address   = 7'd0;
    sample_store_csr_read      = 1'b0;
    sample_store_csr_write     = 1'b0;
    sample_store_csr_writedata = 32'd0;
    smp.sample_valid           = 1'b0;
    done                       = 1'b0;
    case (state)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM: begin
        sample_store_csr_write     = 1'b1;
        sample_store_csr_address   = 7'd64;
        sample_store_csr_writedata = 32'd1;
        state_d                    = S_RUN;
      end
      S_RUN: begin
        sequencer_csr_write     = 1'b1;
        sequencer_csr_writedata = 32'h0000_0003;
        state_d                 = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (sample_store_irq_irq) state_d = S_RD;
        else if (wdog_hit)        state_d = S_STOP;
      end
      S_RD: begin
        sample_store_csr_read    = 1'b1;
        sample_store_csr_address = {1'b0, slot_q};
        state_d                  = S_RWAIT;
      end
      S_RWAIT: if (lat_q == 8'(RD_LAT - 1)) state_d = S_OUT;
      S_OUT: begin
        smp.sample_valid = 1'b1;
        if (smp.sample_ready) state_d = last_slot ? S_CLR : S_RD;
      end
      S_CLR: begin
        done                       = 1'b1;
        sample_store_csr_write     = 1'b1;
        sample_store_csr_address   = 7'd65;
        sample_store_csr_writedata = 32'd1;
        state_d                    = S_STOP;
      end
      S_STOP: begin
        sequencer_csr_write     = 1'b1;
        sequencer_csr_writedata = 32'h0000_0002;
        state_d = (cont_q && !stop_q && !abort_q) ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy            = (state != S_IDLE);
  assign smp.sample_data = data_q;
  assign smp.sample_slot = slot_q;
  assign dbg_state       = state;

`ifdef ADC_SEQ_CTRL_WDOG_EN
  logic [15:0] wdog_cnt;

  // Counter restarts from zero on every WAIT_IRQ entry; an IRQ on the final cycle still wins.
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      wdog_cnt <= '0;
      abort_q  <= 1'b0;
    end else begin
      wdog_cnt <= (state == S_WAIT_IRQ) ? wdog_cnt + 16'd1 : 16'd0;
      if (state == S_IDLE) abort_q <= 1'b0;
      else if (error)      abort_q <= 1'b1;
    end
  end

  assign wdog_hit = (state == S_WAIT_IRQ) && (wdog_cnt == 16'(TMO_CYC - 1));
  assign error    = wdog_hit && !sample_store_irq_irq;
`else
  localparam logic [15:0] unused_tmo = 16'(TMO_CYC);
  assign wdog_hit = 1'b0;
  assign abort_q  = 1'b0;
  assign error    = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{sequencer_csr_readdata, sample_store_csr_readdata[31:12]};

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl: models the ADC core CSR slaves and checks CSR writes and samples.
module tb_adc_seq_ctrl;
  localparam int NSLOT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, cont = 1'b0, stop = 1'b0;
  logic        busy, done, error;
  logic [3:0]  dbg_state;
  logic        seq_addr, seq_read, seq_write;
  logic [31:0] seq_wd;
  logic [31:0] seq_rd = 32'd0;
  logic [6:0]  ss_addr;
  logic        ss_read, ss_write;
  logic [31:0] ss_wd;
  logic [31:0] ss_rd = 32'd0;
  logic        irq = 1'b0;

  adc_seq_ctrl_if sif ();

  adc_seq_ctrl #(.NSLOT(NSLOT), .RD_LAT(2), .TMO_CYC(100)) dut (
    .clock_clk(clk), .reset_sink_reset(rst),
    .start(start), .cont(cont), .stop(stop),
    .busy(busy), .done(done), .smp(sif.master),
    .sequencer_csr_address(seq_addr), .sequencer_csr_read(seq_read),
    .sequencer_csr_write(seq_write), .sequencer_csr_writedata(seq_wd),
    .sequencer_csr_readdata(seq_rd),
    .sample_store_csr_address(ss_addr), .sample_store_csr_read(ss_read),
    .sample_store_csr_write(ss_write), .sample_store_csr_writedata(ss_wd),
    .sample_store_csr_readdata(ss_rd), .sample_store_irq_irq(irq),
    .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [39:0] csr_q[$];
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [39:0] csr_ent(input bit is_seq, input logic [6:0] a, input logic [31:0] d);
    return {is_seq, a, d};
  endfunction

  // ADC core model: 2-cycle read pipeline, IRQ 20 cycles after run=1, cleared by ISR write
  int          rd_base = 0;
  bit          irq_en = 1'b1;
  int          irq_cnt = 0;
  logic [31:0] rd_pend = 32'd0;
  initial begin
    logic c_rd, c_run, c_isr;
    logic [6:0] c_addr;
    forever begin
      @(negedge clk);
      c_rd   = ss_read;
      c_addr = ss_addr;
      c_run  = seq_write && seq_wd[0];
      c_isr  = ss_write && (ss_addr == 7'd65) && (ss_wd == 32'd1);
      @(posedge clk);
      #1;
      if (rst) begin
        irq = 1'b0; irq_cnt = 0; rd_pend = 32'd0; ss_rd = 32'd0;
      end else begin
        ss_rd = rd_pend;
        if (c_rd) rd_pend = 32'(int'(c_addr) * 100 + rd_base);
        if (c_isr) irq = 1'b0;
        if (c_run && irq_en) irq_cnt = 20;
        else if (irq_cnt > 0) begin
          if (irq_cnt == 1) irq = 1'b1;
          irq_cnt--;
        end
      end
    end
  end

  // ready pattern: 0 = always 1, 1 = toggle each cycle, 2 = always 0
  int ready_mode = 0;
  initial begin
    sif.sample_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: sif.sample_ready = 1'b1;
        1: sif.sample_ready = ~sif.sample_ready;
        default: sif.sample_ready = 1'b0;
      endcase
    end
  end

  // monitor
  int          done_cnt = 0, err_cnt = 0, hs_cnt = 0, wcyc = 0, err_at = 0;
  bit          hold_pending = 1'b0;
  logic [18:0] hold_val;
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (seq_write || ss_write) begin
        if (csr_q.size() == 0) begin
          n_checks++;
          $display("FAIL csr_unexpected: got seq=%0b addr=%0d data=0x%0h expected no write",
                   seq_write, seq_write ? 7'd0 : ss_addr, seq_write ? seq_wd : ss_wd);
        end else if (seq_write) check("csr_write", csr_ent(1'b1, {6'd0, seq_addr}, seq_wd), csr_q.pop_front());
        else check("csr_write", csr_ent(1'b0, ss_addr, ss_wd), csr_q.pop_front());
      end
      if (hold_pending)
        check("hold_stable", {sif.sample_valid, sif.sample_slot, sif.sample_data}, hold_val);
      hold_pending = sif.sample_valid && !sif.sample_ready;
      hold_val     = {1'b1, sif.sample_slot, sif.sample_data};
      if (sif.sample_valid && sif.sample_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sample_unexpected: got slot=%0d data=%0d expected none", sif.sample_slot, sif.sample_data);
        end else check("sample", {sif.sample_slot, sif.sample_data}, exp_q.pop_front());
      end
      if (done) done_cnt++;
      wcyc = (dbg_state == 4'd3) ? wcyc + 1 : 0;
      if (error) begin
        err_cnt++;
        err_at = wcyc;
      end
    end
  end

  // driver tasks
  task automatic push_csr(input int nseq);
    csr_q.push_back(csr_ent(1'b0, 7'd64, 32'd1));
    for (int s = 0; s < nseq; s++) begin
      csr_q.push_back(csr_ent(1'b1, 7'd0, 32'h3));
      csr_q.push_back(csr_ent(1'b0, 7'd65, 32'd1));
      csr_q.push_back(csr_ent(1'b1, 7'd0, 32'h2));
    end
  endtask

  task automatic push_samples(input int nseq, input int base);
    for (int s = 0; s < nseq; s++)
      for (int i = 0; i < NSLOT; i++)
        exp_q.push_back({6'(i), 12'(i * 100 + base)});
  endtask

  task automatic pulse(input bit st, input bit c, input bit sp);
    @(posedge clk); #1;
    start = st; cont = c; stop = sp;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check("idle_reached", busy, 0);
  endtask

  int d0;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", sif.sample_valid, 0);
    check("rst_data_slot", {sif.sample_slot, sif.sample_data}, 0);
    check("rst_strobes", {seq_write, seq_read, seq_addr, ss_write, ss_read, done, error}, 0);
    check("rst_addr_wd", {ss_addr, ss_wd, seq_wd}, 0);
    check("rst_state", dbg_state, 0);

    // single sequence, ready always high
    d0 = done_cnt;
    push_csr(1); push_samples(1, 0);
    pulse(1, 0, 0);
    check("busy_after_start", busy, 1);
    wait_idle(400);
    check("done_once", done_cnt - d0, 1);
    check("csr_q_drained", csr_q.size(), 0);
    check("smp_q_drained", exp_q.size(), 0);

    // single sequence, ready toggling
    d0 = done_cnt;
    ready_mode = 1;
    push_csr(1); push_samples(1, 0);
    pulse(1, 0, 0);
    wait_idle(600);
    ready_mode = 0;
    check("toggle_done", done_cnt - d0, 1);
    check("toggle_drained", exp_q.size(), 0);

    // continuous mode, stop during 2nd sequence slot 3
    d0 = done_cnt;
    hs_cnt = 0;
    push_csr(2); push_samples(2, 0);
    pulse(1, 1, 0);
    for (int n = 0; n < 600 && hs_cnt < NSLOT + 3; n++) @(negedge clk);
    check("cont_reached_slot3", sif.sample_slot, 3);
    pulse(0, 0, 1);
    wait_idle(600);
    check("cont_done_twice", done_cnt - d0, 2);
    check("cont_drained", csr_q.size() + exp_q.size(), 0);

    // start while busy ignored, stop in idle ignored
    d0 = done_cnt;
    push_csr(1); push_samples(1, 0);
    pulse(1, 0, 0);
    repeat (3) @(posedge clk);
    pulse(1, 1, 0);
    wait_idle(400);
    pulse(0, 0, 1);
    repeat (40) @(negedge clk);
    check("busy_ignored_done", done_cnt - d0, 1);
    check("idle_stop_no_busy", busy, 0);

    // simultaneous start+stop with cont=1 gives exactly one sequence
    d0 = done_cnt;
    push_csr(1); push_samples(1, 0);
    pulse(1, 1, 1);
    wait_idle(400);
    repeat (40) @(negedge clk);
    check("start_stop_one_seq", done_cnt - d0, 1);
    check("start_stop_drained", csr_q.size() + exp_q.size(), 0);

`ifdef ADC_SEQ_CTRL_WDOG_EN
    // watchdog: irq never arrives
    d0 = done_cnt;
    irq_en = 1'b0;
    csr_q.push_back(csr_ent(1'b0, 7'd64, 32'd1));
    csr_q.push_back(csr_ent(1'b1, 7'd0, 32'h3));
    csr_q.push_back(csr_ent(1'b1, 7'd0, 32'h2));
    pulse(1, 1, 0);
    wait_idle(400);
    irq_en = 1'b1;
    check("wdog_err_once", err_cnt, 1);
    check("wdog_err_cycle", err_at, 100);
    check("wdog_no_done", done_cnt - d0, 0);
    check("wdog_drained", csr_q.size(), 0);
`else
    check("no_error_pulse", err_cnt, 0);
`endif

    // reset while a sample is presented
    ready_mode = 2;
    rd_base = 5;
    csr_q.push_back(csr_ent(1'b0, 7'd64, 32'd1));
    csr_q.push_back(csr_ent(1'b1, 7'd0, 32'h3));
    pulse(1, 0, 0);
    for (int n = 0; n < 200 && !sif.sample_valid; n++) @(negedge clk);
    check("mid_out_valid", {sif.sample_valid, sif.sample_slot, sif.sample_data}, {1'b1, 6'd0, 12'd5});
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_valid", {busy, sif.sample_valid}, 0);
    check("rst_mid_data_slot", {sif.sample_slot, sif.sample_data}, 0);
    check("rst_mid_state", dbg_state, 0);
    check("rst_mid_csr_seen", csr_q.size(), 0);
    ready_mode = 0;
    rd_base = 0;
    repeat (30) @(negedge clk);
    check("rst_mid_stays_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
